// File: rtl/elm_mac_seq_if.sv
// Bundled control/handshake bus between the ELM MAC sequencer and its memories,
// accumulator and downstream consumer.
interface elm_mac_seq_if #(
    parameter int IA_W = 8,
    parameter int WA_W = 16,
    parameter int NI_W = 8
);
    logic            start;
    logic            abort;
    logic            out_ready;
    logic [IA_W-1:0] in_addr;
    logic [WA_W-1:0] w_addr;
    logic            rd_en;
    logic            acc_clr;
    logic            acc_load;
    logic            out_valid;
    logic [NI_W-1:0] out_idx;
    logic            busy;
    logic            done;

    modport master (
        input  start, abort, out_ready,
        output in_addr, w_addr, rd_en, acc_clr, acc_load,
               out_valid, out_idx, busy, done
    );

    modport slave (
        output start, abort, out_ready,
        input  in_addr, w_addr, rd_en, acc_clr, acc_load,
               out_valid, out_idx, busy, done
    );
endinterface

// File: rtl/elm_mac_seq.sv
// Sequencer for an ELM hidden layer: walks N_HID neurons of N_IN MAC terms each,
// driving memory reads and an external accumulator, and hands each sum downstream.
module elm_mac_seq #(
    parameter int N_IN  = 4,
    parameter int N_HID = 3,
    parameter int IA_W  = 8,
    parameter int WA_W  = 16,
    parameter int NI_W  = 8
) (
    input logic          clk,
    input logic          rst,
    elm_mac_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_ACC, S_WAIT, S_OUT, S_DONE
    } state_t;

    localparam logic [IA_W-1:0] K_LAST = IA_W'(N_IN - 1);
    localparam logic [NI_W-1:0] J_LAST = NI_W'(N_HID - 1);

    state_t          state;
    logic [NI_W-1:0] j;
    logic [IA_W-1:0] k;
    // Weight address runs contiguously across neurons, so j*N_IN+k is just a counter.
    logic [WA_W-1:0] w_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            j             <= '0;
            k             <= '0;
            w_cnt         <= '0;
            bus.in_addr   <= '0;
            bus.w_addr    <= '0;
            bus.rd_en     <= 1'b0;
            bus.acc_clr   <= 1'b0;
            bus.acc_load  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_idx   <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else if (bus.abort && state != S_IDLE) begin
            // Cancel: clear the accumulator and drop any load still in flight.
            state         <= S_IDLE;
            bus.rd_en     <= 1'b0;
            bus.acc_clr   <= 1'b1;
            bus.acc_load  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.acc_load <= bus.rd_en;
            case (state)
                S_IDLE: begin
                    bus.acc_clr <= 1'b0;
                    if (bus.start) begin
                        state       <= S_CLR;
                        j           <= '0;
                        w_cnt       <= '0;
                        bus.acc_clr <= 1'b1;
                        bus.busy    <= 1'b1;
                    end
                end
                S_CLR: begin
                    state       <= S_ACC;
                    k           <= '0;
                    bus.acc_clr <= 1'b0;
                    bus.rd_en   <= 1'b1;
                    bus.in_addr <= '0;
                    bus.w_addr  <= w_cnt;
                    w_cnt       <= w_cnt + WA_W'(1);
                end
                S_ACC: begin
                    if (k == K_LAST) begin
                        state     <= S_WAIT;
                        bus.rd_en <= 1'b0;
                    end else begin
                        k           <= k + IA_W'(1);
                        bus.in_addr <= k + IA_W'(1);
                        bus.w_addr  <= w_cnt;
                        w_cnt       <= w_cnt + WA_W'(1);
                    end
                end
                S_WAIT: begin
                    state         <= S_OUT;
                    bus.out_valid <= 1'b1;
                    bus.out_idx   <= j;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (j == J_LAST) begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state       <= S_CLR;
                            j           <= j + NI_W'(1);
                            bus.acc_clr <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_elm_mac_seq.sv
// Randomized self-checking bench for elm_mac_seq with a memory (data=address+1)
// and accumulator attached; timing and sums come from a cycle-timeline model.
module tb_elm_mac_seq;
    localparam int N_IN  = 4;
    localparam int N_HID = 3;
    localparam int IA_W  = 8;
    localparam int WA_W  = 16;
    localparam int NI_W  = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    elm_mac_seq_if #(.IA_W(IA_W), .WA_W(WA_W), .NI_W(NI_W)) bus ();

    elm_mac_seq #(.N_IN(N_IN), .N_HID(N_HID), .IA_W(IA_W), .WA_W(WA_W), .NI_W(NI_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory with one-cycle read latency feeding a clear/load accumulator.
    logic [31:0] in_d, w_d, acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            in_d <= '0;
            w_d  <= '0;
            acc  <= '0;
        end else begin
            if (bus.rd_en) begin
                in_d <= 32'(bus.in_addr) + 32'd1;
                w_d  <= 32'(bus.w_addr) + 32'd1;
            end
            if (bus.acc_clr)       acc <= '0;
            else if (bus.acc_load) acc <= acc + in_d * w_d;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] vec();
        return {bus.busy, bus.done, bus.out_valid, bus.rd_en, bus.acc_clr, bus.acc_load};
    endfunction

    function automatic longint ref_sum(input int j);
        longint s = 0;
        for (int k = 0; k < N_IN; k++) s += longint'((k + 1) * (j * N_IN + k + 1));
        return s;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, vec(), 0);
        chk({tag, "_in_addr"}, bus.in_addr, 0);
        chk({tag, "_w_addr"}, bus.w_addr, 0);
        chk({tag, "_out_idx"}, bus.out_idx, 0);
    endtask

    // mode 0: out_ready high, 1: neuron 1 stalled 5 cycles, 2: random out_ready.
    // Cycle 0 is the start pulse; each neuron spans CLR, N_IN reads, WAIT, then OUT
    // until handshake, with the next CLR on the following cycle.
    task automatic run_pass(input int mode, input int abort_at, input int rst_at, input bit restart);
        int c = 0, j_m = 0, t0 = 1, done_c = -1, hs = 0, n_done = 0, ov1 = 0, stall = 0, ph;
        bit rdy, abort_pend = 0, reset_hit = 0;
        logic [5:0] exp_v;
        bus.start = 1'b1;
        forever begin
            step();
            c++;
            if (c > 400) begin
                chk("timeout", c, 0);
                break;
            end
            if (bus.done) n_done++;
            if (abort_pend) begin
                chk("abort_next", vec(), 6'b000010);
                bus.abort = 1'b0;
                step();
                if (bus.done) n_done++;
                chk("abort_settle", vec(), 0);
                break;
            end
            if (done_c > 0 && c > done_c) begin
                chk("idle_after_done", vec(), 0);
                break;
            end
            ph = c - t0;
            if (c == done_c) exp_v = 6'b110000;
            else exp_v = {1'b1, 1'b0, ph >= N_IN + 2, ph >= 1 && ph <= N_IN, ph == 0,
                          ph >= 2 && ph <= N_IN + 1};
            chk($sformatf("ctl_c%0d", c), vec(), exp_v);
            if (c != done_c && ph >= 1 && ph <= N_IN) begin
                chk($sformatf("in_addr_c%0d", c), bus.in_addr, ph - 1);
                chk($sformatf("w_addr_c%0d", c), bus.w_addr, j_m * N_IN + ph - 1);
            end
            if (c != done_c && ph >= N_IN + 2) chk($sformatf("out_idx_c%0d", c), bus.out_idx, j_m);

            bus.start = restart && (ph == 2 || c == done_c);
            case (mode)
                1:       rdy = !(j_m == 1 && stall < 5);
                2:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = 1'b1;
            endcase
            if (bus.out_valid && j_m == 1) begin
                ov1++;
                if (!rdy) stall++;
            end
            bus.out_ready = rdy;

            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                chk_zero("async_rst");
                step();
                rst = 1'b0;
                reset_hit = 1;
                break;
            end
            if (c == abort_at) begin
                bus.abort  = 1'b1;
                abort_pend = 1;
            end else if (bus.out_valid && rdy) begin
                hs++;
                chk($sformatf("sum_n%0d", j_m), acc, ref_sum(j_m));
                if (j_m == N_HID - 1) done_c = c + 1;
                else begin
                    j_m++;
                    t0 = c + 1;
                end
            end
        end
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;
        if (abort_at >= 0) chk("abort_no_done", n_done, 0);
        else if (!reset_hit) begin
            chk("handshakes", hs, N_HID);
            chk("done_pulses", n_done, 1);
        end
        if (mode == 1) chk("stall_ov_cycles", ov1, 6);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk_zero("in_reset");
        rst = 1'b0;
        repeat (3) step();
        chk_zero("post_reset");

        run_pass(0, -1, -1, 0);
        run_pass(1, -1, -1, 0);
        run_pass(0, 11, -1, 0);
        repeat (2) step();
        run_pass(0, -1, 7, 0);
        run_pass(0, -1, -1, 0);
        for (int i = 0; i < 4; i++) run_pass(2, -1, -1, 1);
        run_pass(2, 5 + 7 * $urandom_range(0, 2), -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/elm_mac_seq.md
ELM_MAC_SEQ -- requirements
Module: elm_mac_seq

Interface
REQ-001 Parameter N_IN, default 4: input features (MAC terms) per hidden neuron, >=2.
REQ-002 Parameter N_HID, default 3: hidden neurons per pass, >=1.
REQ-003 Parameter IA_W, default 8: input address width; WA_W, default 16: weight address width; NI_W, default 8: neuron index width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  begin pass; sampled only in IDLE.
REQ-007 abort  in  1  synchronous cancel of an in-progress pass.
REQ-008 in_addr  out  IA_W  input-vector memory read address.
REQ-009 w_addr  out  WA_W  weight memory read address.
REQ-010 rd_en  out  1  memory read strobe; read data valid one cycle later.
REQ-011 acc_clr  out  1  drives accumulator synchronous clear (RST).
REQ-012 acc_load  out  1  drives accumulator load.
REQ-013 out_valid  out  1  accumulator holds a finished neuron sum.
REQ-014 out_idx  out  NI_W  neuron index of the finished sum.
REQ-015 out_ready  in  1  downstream consumes sum when out_valid & out_ready.
REQ-016 busy  out  1  high in every state except IDLE; done  out  1  one-cycle end-of-pass pulse.

Function
REQ-017 States: IDLE, CLR, ACC, WAIT, OUT, DONE; encoding free.
REQ-018 IDLE: start=1 -> CLR, neuron index j=0; otherwise stay.
REQ-019 CLR: acc_clr=1 for exactly one cycle, term counter k=0 -> ACC.
REQ-020 ACC: rd_en=1, in_addr=k, w_addr=j*N_IN+k; k increments each cycle; at k=N_IN-1 -> WAIT.
REQ-021 acc_load is rd_en delayed by one cycle (memory latency 1); acc_load=1 in WAIT cycle for last term.
REQ-022 WAIT: rd_en=0 -> OUT.
REQ-023 OUT: out_valid=1, out_idx=j, acc_load=0, acc_clr=0; hold until out_ready=1; on handshake: j<N_HID-1 -> j+1, CLR; j=N_HID-1 -> DONE.
REQ-024 DONE: done=1 one cycle -> IDLE.
REQ-025 acc_clr and acc_load never both high in the same cycle.
REQ-026 Per-neuron latency with out_ready held high: N_IN+3 cycles (CLR 1, ACC N_IN, WAIT 1, OUT 1); full pass N_HID*(N_IN+3)+1 cycles from first CLR to end of DONE.
REQ-027 start while busy=1 is ignored; start in DONE cycle is ignored.
REQ-028 abort=1 in any non-IDLE state: next cycle -> IDLE, acc_clr=1 that cycle, done not pulsed, pending delayed acc_load suppressed; abort has priority over out_ready.
REQ-029 w_addr arithmetic unsigned, computed without truncation within WA_W; N_IN*N_HID <= 2^WA_W is a parameter precondition.
REQ-030 Outputs registered; no combinational path from start/out_ready/abort to any output.

Reset
REQ-031 rst=1 forces IDLE asynchronously; j=0, k=0.
REQ-032 During and after reset until first start: in_addr=0, w_addr=0, rd_en=0, acc_clr=0, acc_load=0, out_valid=0, out_idx=0, busy=0, done=0.
REQ-033 rst mid-pass drops busy/out_valid immediately; the next pass starts from j=0 with a CLR.

Verification
REQ-034 N_IN=4,N_HID=3, start pulse, out_ready=1 -> acc_clr at cycle 1, w_addr 0,1,2,3 cycles 2-5, acc_load cycles 3-6, out_valid out_idx=0 cycle 7; out_idx 1,2 follow every 7 cycles; done at cycle 22.
REQ-035 Same, out_ready low 5 cycles on neuron 1 -> out_valid, out_idx=1 held steady 6 cycles, no acc_clr/acc_load during stall, w_addr resumes at 8.
REQ-036 abort asserted during ACC of neuron 1 at k=2 -> next cycle IDLE, busy=0, acc_clr=1, acc_load=0, done never pulses.
REQ-037 start re-pulsed during ACC and in DONE -> ignored; pass ends with exactly 3 out handshakes and one done.
REQ-038 rst asserted asynchronously mid-OUT -> outputs to REQ-032 values before next clock edge; new start yields clean pass from out_idx=0.
REQ-039 Connected to accumulator with memory model data=address+1 -> neuron j sum equals sum over k of (k+1)*(j*4+k+1), checked against model for all 3 neurons.
